// File: rtl/crc_append_send_b.sv
// Transmit FCS generator: passes 16-bit payload words through and appends
// the 4-byte Ethernet CRC-32, handling an odd trailing byte.
module crc_append_send_b (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  input  logic        i_last,
  input  logic        i_odd,
  output logic        o_ready,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_odd,
  input  logic        i_ready
);

  typedef enum logic [1:0] {
    PASS,
    FCS_A,
    FCS_B
  } state_t;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  // MSB-first shift register fed with each byte LSB-first
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  // packs {B0,B1,B2,B3}, Bk bit i = ~C[31-8k-i]
  function automatic logic [31:0] fcs_of(input logic [31:0] c);
    logic [31:0] f;
    f = '0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        f[24-8*k+i] = ~c[31-8*k-i];
    return f;
  endfunction

  state_t      state;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic        odd_r;

  logic [31:0] crc_w;
  logic [31:0] crc_b;
  logic [31:0] fcs_w;
  logic [31:0] fcs_b;
  logic        free;
  logic        accept;

  assign crc_b  = crc_byte(crc, i_data[15:8]);
  assign crc_w  = crc_byte(crc_b, i_data[7:0]);
  assign fcs_w  = fcs_of(crc_w);
  assign fcs_b  = fcs_of(crc_b);
  assign free   = !o_valid || i_ready;
  assign o_ready = (state == PASS) && free;
  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= PASS;
      crc     <= 32'hFFFF_FFFF;
      fcs     <= '0;
      odd_r   <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_odd   <= 1'b0;
    end else begin
      unique case (state)
        PASS: begin
          if (accept) begin
            o_valid <= 1'b1;
            o_last  <= 1'b0;
            o_odd   <= 1'b0;
            if (!i_last) begin
              o_data <= i_data;
              crc    <= crc_w;
            end else if (!i_odd) begin
              o_data <= i_data;
              fcs    <= fcs_w;
              odd_r  <= 1'b0;
              state  <= FCS_A;
            end else begin
              o_data <= {i_data[15:8], fcs_b[31:24]};
              fcs    <= fcs_b;
              odd_r  <= 1'b1;
              state  <= FCS_A;
            end
          end else if (free) begin
            o_valid <= 1'b0;
          end
        end
        FCS_A: begin
          if (free) begin
            o_valid <= 1'b1;
            o_data  <= odd_r ? fcs[23:8] : fcs[31:16];
            state   <= FCS_B;
          end
        end
        FCS_B: begin
          if (free) begin
            o_valid <= 1'b1;
            o_data  <= odd_r ? {fcs[7:0], 8'h00} : fcs[15:0];
            o_last  <= 1'b1;
            o_odd   <= odd_r;
            crc     <= 32'hFFFF_FFFF;
            state   <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_append_send_b.sv
// Bench for crc_append_send_b: directed frames, random frames with random
// backpressure, mid-frame reset, and receive-side residue checks.
module tb_crc_append_send_b;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_data;
  logic        i_valid;
  logic        i_last;
  logic        i_odd;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_odd;
  logic        i_ready;

  int total = 0;
  int bad   = 0;

  logic [15:0] rx_d[$];
  logic        rx_l[$];
  logic        rx_o[$];

  crc_append_send_b dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_odd  (i_odd),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_last (o_last),
    .o_odd  (o_odd),
    .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reflected (LSB-first) CRC-32, register value without final inversion
  function automatic logic [31:0] ref_crc(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[n]) begin
      c ^= {24'h0, q[n]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic run_frame(input bq_t pl, input int rdy_pct,
                           input int abort_after);
    bq_t exp;
    bq_t got;
    logic [15:0] ew[$];
    logic        el[$];
    logic        eo[$];
    logic [31:0] f;
    logic [15:0] pd;
    logic        pl_l;
    logic        po;
    logic        stalled;
    int nin;
    int wi;
    int cyc;
    exp = pl;
    f = ~ref_crc(pl);
    exp.push_back(f[7:0]);
    exp.push_back(f[15:8]);
    exp.push_back(f[23:16]);
    exp.push_back(f[31:24]);
    for (int j = 0; 2 * j < exp.size(); j++) begin
      ew.push_back({exp[2*j], (2*j+1 < exp.size()) ? exp[2*j+1] : 8'h00});
      el.push_back(2*j+2 >= exp.size());
      eo.push_back((2*j+2 >= exp.size()) && (exp.size() % 2 == 1));
    end
    nin = (pl.size() + 1) / 2;
    rx_d.delete(); rx_l.delete(); rx_o.delete();
    wi = 0; cyc = 0; stalled = 1'b0;
    pd = '0; pl_l = 1'b0; po = 1'b0;
    while (rx_d.size() < ew.size() && cyc < 2000) begin
      @(negedge clk);
      i_ready = ($urandom_range(99) < rdy_pct);
      if (wi < nin) begin
        i_valid = 1'b1;
        i_data  = {pl[2*wi], (2*wi+1 < pl.size()) ? pl[2*wi+1]
                                                  : 8'($urandom)};
        i_last  = (wi == nin - 1);
        i_odd   = i_last ? (pl.size() % 2 == 1) : 1'($urandom);
      end else begin
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_odd   = 1'b0;
      end
      #1;
      if (stalled)
        chk("stall_hold", {14'h0, o_data, o_last, o_odd},
            {14'h0, pd, pl_l, po});
      if (o_valid && i_ready) begin
        rx_d.push_back(o_data);
        rx_l.push_back(o_last);
        rx_o.push_back(o_odd);
      end
      if (i_valid && o_ready) wi++;
      stalled = o_valid && !i_ready;
      pd = o_data; pl_l = o_last; po = o_odd;
      cyc++;
      if (abort_after >= 0 && wi == abort_after) break;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_odd   = 1'b0;
    i_ready = 1'b1;
    if (abort_after < 0) begin
      chk("word_count", rx_d.size(), ew.size());
      chk("idle_after", {31'h0, o_valid}, 32'h0);
      foreach (rx_d[j]) begin
        chk($sformatf("word%0d", j), {14'h0, rx_d[j], rx_l[j], rx_o[j]},
            {14'h0, ew[j], el[j], eo[j]});
        got.push_back(rx_d[j][15:8]);
        if (!(rx_l[j] && rx_o[j])) got.push_back(rx_d[j][7:0]);
      end
      chk("residue", bitrev(ref_crc(got)), 32'hC704_DD7B);
    end
  endtask

  task automatic chk_rx(input string tag, input logic [15:0] k[]);
    chk({tag, "_len"}, rx_d.size(), k.size());
    foreach (k[j])
      if (j < rx_d.size())
        chk($sformatf("%s_%0d", tag, j), {16'h0, rx_d[j]}, {16'h0, k[j]});
  endtask

  initial begin
    bq_t s9;
    bq_t s8;
    bq_t sa;
    bq_t r;
    logic [15:0] k9[];
    logic [15:0] k8[];
    logic [15:0] ka[];
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    s8 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    sa = '{8'h61};
    k9 = '{16'h3132, 16'h3334, 16'h3536, 16'h3738,
           16'h3926, 16'h39F4, 16'hCB00};
    k8 = '{16'h3132, 16'h3334, 16'h3536, 16'h3738, 16'hAFDA, 16'hE09A};
    ka = '{16'h6143, 16'hBEB7, 16'hE800};

    rst = 1'b1;
    i_valid = 1'b0; i_last = 1'b0; i_odd = 1'b0;
    i_data = '0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_data", {16'h0, o_data}, 32'h0);
    chk("rst_flags", {30'h0, o_last, o_odd}, 32'h0);
    chk("rst_ready", {31'h0, o_ready}, 32'h1);

    run_frame(s9, 100, -1);
    chk_rx("odd9", k9);
    run_frame(s8, 100, -1);
    chk_rx("even8", k8);
    run_frame(sa, 100, -1);
    chk_rx("one_a", ka);
    run_frame(s8, 100, -1);
    chk_rx("even8_after_a", k8);
    run_frame(s8, 50, -1);
    chk_rx("even8_bp", k8);

    run_frame(s9, 100, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'h0, o_valid}, 32'h0);
    chk("midrst_ready", {31'h0, o_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_ready", {31'h0, o_ready}, 32'h1);
    run_frame(s9, 100, -1);
    chk_rx("odd9_after_rst", k9);

    for (int f = 0; f < 100; f++) begin
      r.delete();
      for (int b = $urandom_range(40, 1); b > 0; b--)
        r.push_back(8'($urandom));
      run_frame(r, $urandom_range(100, 30), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
